// File: rtl/mips_defs.sv
// Shared MIPS-subset encodings used by the ID stage and its register file.
package mips_defs;

    localparam int REG_ADDR_W = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] PC_CHOICE_PCP4   = 2'b00;
    localparam logic [1:0] PC_CHOICE_BRANCH = 2'b01;
    localparam logic [1:0] PC_CHOICE_JUMP   = 2'b10;
    localparam logic [1:0] PC_CHOICE_JR     = 2'b11;

endpackage

// File: rtl/reg_file.sv
// 32x32 GPR file: two combinational read ports with same-cycle WB write-through,
// one synchronous write port; $0 is hardwired to zero.
module reg_file
    import mips_defs::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [31:0]           rdata_a,
    output logic [31:0]           rdata_b
);

    logic [31:0] regs_q [DEPTH];
    logic [31:0] regs_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Write-through lets ID see the value WB is committing this very cycle.
    always_comb begin
        rdata_a = regs_q[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = regs_q[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipeline ID stage: IF/ID register, GPR read with MEM/WB forwarding,
// immediate extension and branch/jump resolution returned to the fetcher.
module decode_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PCP4 = RESET_PC + 32'd4,
    parameter int          RF_DEPTH   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] if_ir,
    input  logic [31:0] if_pcp4,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mem_fwd_en,
    input  logic [4:0]  mem_fwd_addr,
    input  logic [31:0] mem_fwd_data,
    output logic [31:0] id_ir,
    output logic [31:0] id_pcp4,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] ext_imm32,
    output logic [31:0] sign_imm32,
    output logic [25:0] addr26,
    output logic [31:0] ra32,
    output logic [1:0]  pc_choice,
    output logic [31:0] link_pc
);

    logic [31:0] id_ir_q, id_ir_d;
    logic [31:0] id_pcp4_q, id_pcp4_d;

    always_comb begin
        id_ir_d   = id_ir_q;
        id_pcp4_d = id_pcp4_q;
        if (!stall) begin
            id_ir_d   = if_ir;
            id_pcp4_d = if_pcp4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ir_q   <= '0;
            id_pcp4_q <= RESET_PCP4;
        end else begin
            id_ir_q   <= id_ir_d;
            id_pcp4_q <= id_pcp4_d;
        end
    end

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [15:0] imm16;
    logic [31:0] rf_rs;
    logic [31:0] rf_rt;

    assign opcode = id_ir_q[31:26];
    assign rs_idx = id_ir_q[25:21];
    assign rt_idx = id_ir_q[20:16];
    assign imm16  = id_ir_q[15:0];
    assign funct  = id_ir_q[5:0];

    reg_file #(
        .DEPTH(RF_DEPTH)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (rf_rs),
        .rdata_b (rf_rt)
    );

    // MEM is younger than WB, so its result overrides the write-through value.
    always_comb begin
        rs_data = rf_rs;
        if (rs_idx == '0) begin
            rs_data = '0;
        end else if (mem_fwd_en && (mem_fwd_addr == rs_idx)) begin
            rs_data = mem_fwd_data;
        end
    end

    always_comb begin
        rt_data = rf_rt;
        if (rt_idx == '0) begin
            rt_data = '0;
        end else if (mem_fwd_en && (mem_fwd_addr == rt_idx)) begin
            rt_data = mem_fwd_data;
        end
    end

    always_comb begin
        sign_imm32 = {{16{imm16[15]}}, imm16};
        ext_imm32  = sign_imm32;
        if (opcode == OP_ORI) begin
            ext_imm32 = {16'h0000, imm16};
        end else if (opcode == OP_LUI) begin
            ext_imm32 = {imm16, 16'h0000};
        end
    end

    always_comb begin
        pc_choice = PC_CHOICE_PCP4;
        case (opcode)
            OP_BEQ:   pc_choice = (rs_data == rt_data) ? PC_CHOICE_BRANCH : PC_CHOICE_PCP4;
            OP_BNE:   pc_choice = (rs_data != rt_data) ? PC_CHOICE_BRANCH : PC_CHOICE_PCP4;
            OP_J,
            OP_JAL:   pc_choice = PC_CHOICE_JUMP;
            OP_RTYPE: pc_choice = (funct == FN_JR) ? PC_CHOICE_JR : PC_CHOICE_PCP4;
            default:  pc_choice = PC_CHOICE_PCP4;
        endcase
    end

    assign id_ir   = id_ir_q;
    assign id_pcp4 = id_pcp4_q;
    assign addr26  = id_ir_q[25:0];
    assign ra32    = rs_data;
    assign link_pc = id_pcp4_q + 32'd4;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded instructions with hand-computed results.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] if_ir, if_pcp4;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_addr;
    logic [31:0] mem_fwd_data;
    logic [31:0] id_ir, id_pcp4, rs_data, rt_data, ext_imm32, sign_imm32, ra32, link_pc;
    logic [25:0] addr26;
    logic [1:0]  pc_choice;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] I_ORI  = 32'h34A6_8001; // ori  $6,$5,0x8001
    localparam logic [31:0] I_BEQ  = 32'h1022_FFFC; // beq  $1,$2,-4
    localparam logic [31:0] I_BNE  = 32'h1422_FFFC; // bne  $1,$2,-4
    localparam logic [31:0] I_JR   = 32'h03E0_0008; // jr   $31
    localparam logic [31:0] I_JAL  = 32'h0C00_0C10; // jal  0x0000C10
    localparam logic [31:0] I_LUI  = 32'h3C03_ABCD; // lui  $3,0xABCD
    localparam logic [31:0] I_LW   = 32'h8C22_1234; // lw   $2,0x1234($1)
    localparam logic [31:0] I_BAD  = 32'hFC00_0000; // undefined opcode 3f

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .if_ir        (if_ir),
        .if_pcp4      (if_pcp4),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .mem_fwd_en   (mem_fwd_en),
        .mem_fwd_addr (mem_fwd_addr),
        .mem_fwd_data (mem_fwd_data),
        .id_ir        (id_ir),
        .id_pcp4      (id_pcp4),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .ext_imm32    (ext_imm32),
        .sign_imm32   (sign_imm32),
        .addr26       (addr26),
        .ra32         (ra32),
        .pc_choice    (pc_choice),
        .link_pc      (link_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] ir, input logic [31:0] pcp4);
        if_ir   = ir;
        if_pcp4 = pcp4;
        tick();
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; if_ir = 32'hFFFF_FFFF; if_pcp4 = 32'hDEAD_BEEF;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        mem_fwd_en = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
        tick(); tick();
        tests++; if (id_ir !== 32'h0) begin fails++; $display("FAIL reset_id_ir got %h exp %h", id_ir, 32'h0); end
        tests++; if (id_pcp4 !== 32'h3004) begin fails++; $display("FAIL reset_id_pcp4 got %h exp %h", id_pcp4, 32'h3004); end
        tests++; if (pc_choice !== 2'b00) begin fails++; $display("FAIL reset_pc_choice got %b exp 00", pc_choice); end
        tests++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin fails++; $display("FAIL reset_operands got %h/%h exp 0/0", rs_data, rt_data); end
        reset = 1'b0; if_ir = 32'h0; if_pcp4 = 32'h3004;
        tick();
        tests++; if (id_ir !== 32'h0 || id_pcp4 !== 32'h3004) begin fails++; $display("FAIL release_ifid got %h/%h exp 0/3004", id_ir, id_pcp4); end
    endtask

    task automatic test_ori_imm();
        wb_write(5'd5, 32'h1234_5678);
        load_ir(I_ORI, 32'h3008);
        tests++; if (rs_data !== 32'h1234_5678) begin fails++; $display("FAIL ori_rs_data got %h exp %h", rs_data, 32'h1234_5678); end
        tests++; if (ext_imm32 !== 32'h0000_8001) begin fails++; $display("FAIL ori_ext_imm got %h exp %h", ext_imm32, 32'h0000_8001); end
        tests++; if (sign_imm32 !== 32'hFFFF_8001) begin fails++; $display("FAIL ori_sign_imm got %h exp %h", sign_imm32, 32'hFFFF_8001); end
        tests++; if (pc_choice !== 2'b00) begin fails++; $display("FAIL ori_pc_choice got %b exp 00", pc_choice); end
        load_ir(I_LUI, 32'h300C);
        tests++; if (ext_imm32 !== 32'hABCD_0000) begin fails++; $display("FAIL lui_ext_imm got %h exp %h", ext_imm32, 32'hABCD_0000); end
        tests++; if (sign_imm32 !== 32'hFFFF_ABCD) begin fails++; $display("FAIL lui_sign_imm got %h exp %h", sign_imm32, 32'hFFFF_ABCD); end
        load_ir(I_LW, 32'h3010);
        tests++; if (ext_imm32 !== 32'h0000_1234) begin fails++; $display("FAIL lw_ext_imm got %h exp %h", ext_imm32, 32'h0000_1234); end
        load_ir(I_BAD, 32'h3014);
        tests++; if (pc_choice !== 2'b00) begin fails++; $display("FAIL bad_op_pc_choice got %b exp 00", pc_choice); end
    endtask

    task automatic test_branch();
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        load_ir(I_BEQ, 32'h3018);
        tests++; if (pc_choice !== 2'b01) begin fails++; $display("FAIL beq_taken got %b exp 01", pc_choice); end
        tests++; if (sign_imm32 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL beq_sign_imm got %h exp %h", sign_imm32, 32'hFFFF_FFFC); end
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd2; mem_fwd_data = 32'd8;
        #1;
        tests++; if (rt_data !== 32'd8) begin fails++; $display("FAIL beq_mem_fwd_rt got %h exp %h", rt_data, 32'd8); end
        tests++; if (pc_choice !== 2'b00) begin fails++; $display("FAIL beq_not_taken got %b exp 00", pc_choice); end
        load_ir(I_BNE, 32'h301C);
        tests++; if (pc_choice !== 2'b01) begin fails++; $display("FAIL bne_taken got %b exp 01", pc_choice); end
        mem_fwd_en = 1'b0;
        #1;
        tests++; if (pc_choice !== 2'b00) begin fails++; $display("FAIL bne_not_taken got %b exp 00", pc_choice); end
        mem_fwd_addr = '0; mem_fwd_data = '0;
    endtask

    task automatic test_jr_forward();
        wb_write(5'd31, 32'h3000);
        load_ir(I_JR, 32'h3020);
        tests++; if (ra32 !== 32'h3000) begin fails++; $display("FAIL jr_ra32_rf got %h exp %h", ra32, 32'h3000); end
        wb_we = 1'b1; wb_addr = 5'd31; wb_data = 32'h3010;
        #1;
        tests++; if (ra32 !== 32'h3010) begin fails++; $display("FAIL jr_ra32_wb got %h exp %h", ra32, 32'h3010); end
        tests++; if (pc_choice !== 2'b11) begin fails++; $display("FAIL jr_pc_choice got %b exp 11", pc_choice); end
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd31; mem_fwd_data = 32'h4000;
        #1;
        tests++; if (ra32 !== 32'h4000) begin fails++; $display("FAIL jr_mem_over_wb got %h exp %h", ra32, 32'h4000); end
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        mem_fwd_en = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
        #1;
        tests++; if (ra32 !== 32'h3000) begin fails++; $display("FAIL jr_ra32_restore got %h exp %h", ra32, 32'h3000); end
    endtask

    task automatic test_stall();
        load_ir(I_LUI, 32'h3024);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_ir(32'h1111_0000 + i, 32'h4000 + 4 * i);
            tests++; if (id_ir !== I_LUI || id_pcp4 !== 32'h3024) begin fails++; $display("FAIL stall_hold_%0d got %h/%h exp %h/%h", i, id_ir, id_pcp4, I_LUI, 32'h3024); end
        end
        stall = 1'b0;
        load_ir(I_LW, 32'h5000);
        tests++; if (id_ir !== I_LW || id_pcp4 !== 32'h5000) begin fails++; $display("FAIL stall_release got %h/%h exp %h/%h", id_ir, id_pcp4, I_LW, 32'h5000); end
    endtask

    task automatic test_jal_zero();
        load_ir(I_JAL, 32'h3008);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (rs_data !== 32'h0) begin fails++; $display("FAIL jal_r0_writethrough got %h exp 0", rs_data); end
        tests++; if (pc_choice !== 2'b10) begin fails++; $display("FAIL jal_pc_choice got %b exp 10", pc_choice); end
        tests++; if (addr26 !== 26'h0000C10) begin fails++; $display("FAIL jal_addr26 got %h exp %h", addr26, 26'h0000C10); end
        tests++; if (link_pc !== 32'h300C) begin fails++; $display("FAIL jal_link_pc got %h exp %h", link_pc, 32'h300C); end
        stall = 1'b1;
        tick();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        #1;
        tests++; if (rs_data !== 32'h0) begin fails++; $display("FAIL r0_after_write got %h exp 0", rs_data); end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        load_ir(I_ORI, 32'h6000);
        stall = 1'b1; if_ir = I_BEQ; if_pcp4 = 32'h7000;
        reset = 1'b1;
        tick();
        tests++; if (id_ir !== 32'h0 || id_pcp4 !== 32'h3004) begin fails++; $display("FAIL reset_mid_stall got %h/%h exp 0/3004", id_ir, id_pcp4); end
        reset = 1'b0; stall = 1'b0;
        load_ir(I_ORI, 32'h3008);
        tests++; if (rs_data !== 32'h0) begin fails++; $display("FAIL reset_clears_gpr5 got %h exp 0", rs_data); end
    endtask

    initial begin
        test_reset();
        test_ori_imm();
        test_branch();
        test_jr_forward();
        test_stall();
        test_jal_zero();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Pipeline ID stage, directly downstream of the instruction fetcher.
- Latches the fetched instruction and PC+4 into the IF/ID register.
- Holds the 32x32 general-purpose register file, with write-back bypass and MEM/WB forwarding.
- Resolves branches and jumps in ID and returns next-PC controls (sign_imm32, addr26, ra32, pc_choice) to the fetcher.
- Branches are delayed: the delay slot always executes, so there is no IF/ID flush.

Parameters:
RESET_PCP4, 32'h00003004, id_pcp4 value after reset
RF_DEPTH, 32, number of GPRs (index width 5)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
stall  input  1  from hazard unit; same net as fetcher FREEZE; holds IF/ID
if_ir  input  32  instruction from fetcher
if_pcp4  input  32  fetcher PC+4
wb_we  input  1  register-file write enable from WB
wb_addr  input  5  WB destination register
wb_data  input  32  WB write data
mem_fwd_en  input  1  MEM stage holds a valid result
mem_fwd_addr  input  5  MEM destination register
mem_fwd_data  input  32  MEM result
id_ir  output  32  latched instruction
id_pcp4  output  32  latched PC+4
rs_data  output  32  forwarded GPR[rs]
rt_data  output  32  forwarded GPR[rt]
ext_imm32  output  32  ALU immediate; zero-extended for ori, imm<<16 for lui, sign-extended otherwise
sign_imm32  output  32  sign-extended imm16, unshifted, to fetcher
addr26  output  26  id_ir[25:0], to fetcher
ra32  output  32  forwarded GPR[rs], jr target, to fetcher
pc_choice  output  2  00 PC+4, 01 branch, 10 j/jal, 11 jr
link_pc  output  32  id_pcp4+4, return address for jal

Behaviour:
- Clock and reset: all state updates on posedge clk. reset has priority over stall.
- Reset values:
  - id_ir=0 (nop), id_pcp4=RESET_PCP4.
  - All GPRs cleared to 0.
  - Resulting outputs: pc_choice=00, rs_data=rt_data=0.
- IF/ID register:
  - stall=0: id_ir<=if_ir, id_pcp4<=if_pcp4.
  - stall=1: both hold.
- Register file:
  - Write on posedge when wb_we=1 and wb_addr!=0.
  - Writes to $0 are ignored; $0 always reads 0.
  - Register-file writes are not gated by stall.
- Operand read priority, applied independently to rs (id_ir[25:21]) and rt (id_ir[20:16]), highest first:
  1. index 0 -> 0.
  2. mem_fwd_en && mem_fwd_addr==index -> mem_fwd_data.
  3. wb_we && wb_addr==index -> wb_data (same-cycle write-through).
  4. otherwise GPR contents.
- Decoded opcodes; anything else decodes as a nop with pc_choice=00:
  - R-type (op 0): addu (funct 21), subu (23), jr (08).
  - ori 0d, lui 0f, lw 23, sw 2b, beq 04, bne 05, j 02, jal 03.
- pc_choice, combinational from id_ir and forwarded operands:
  - beq: 01 if rs_data==rt_data, else 00.
  - bne: 01 if rs_data!=rt_data, else 00.
  - j, jal: 10.
  - jr: 11.
  - all others: 00.
- Target arithmetic is done entirely in the fetcher's next-PC logic. This block supplies only the raw operands.
- pc_choice is meaningful only when stall=0; the fetcher ignores it while frozen. No extra gating is required.
- Boundary cases:
  - if_ir=0 latches a nop.
  - A jal in ID with a branch in the delay slot is not supported; the hazard unit prevents it.
  - A WB write and a MEM forward to the same register in the same cycle: MEM wins.
  - Reset asserted mid-stall clears IF/ID to the reset values.

Decomposition:
- Shared package, mips_defs: opcode and funct localparams, PC_CHOICE_* encodings (00/01/10/11), RESET_PC 32'h00003000.
- One sub-module, reg_file: 32x32 storage, two combinational read ports with WB write-through, one synchronous write port, synchronous reset.
- decode_stage contains:
  - the IF/ID register;
  - the forwarding muxes;
  - immediate extension;
  - branch comparison and pc_choice logic.

Test Plan:
- Reset then release, if_ir=0 -> id_pcp4=32'h00003004, id_ir=0, pc_choice=00, rs_data=rt_data=0.
- Write GPR5=32'h12345678 via WB; next cycle id_ir=ori $6,$5,0x8001 -> rs_data=32'h12345678, ext_imm32=32'h00008001, sign_imm32=32'hFFFF8001.
- id_ir=beq $1,$2,-4, GPR1=GPR2=7 -> pc_choice=01, sign_imm32=32'hFFFFFFFC. Then mem_fwd_en=1, mem_fwd_addr=2, mem_fwd_data=8 -> pc_choice=00.
- id_ir=jr $31, GPR31=32'h3000, with wb_we=1, wb_addr=31, wb_data=32'h3010 in the same cycle -> ra32=32'h3010, pc_choice=11.
- stall=1 for 3 cycles while if_ir changes -> id_ir and id_pcp4 unchanged. Then stall=0 -> capture the current if_ir.
- jal 0x0000C10 at id_pcp4=32'h3008 -> pc_choice=10, addr26=26'h0000C10, link_pc=32'h300C. A WB write to $0 leaves rs_data=0.
